// File: rtl/priority_encoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_seq_if
// Description : Handshake bundle for priority_encoder_seq. The producer side
//               (in_*) and the consumer side (out_*) are carried together; the
//               slave modport is the encoder, the master modport is the
//               environment that feeds it and drains results.
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_encoder_seq_if #(
    parameter int N  = 4,
    parameter int CW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic          out_none;
    logic          out_multi;
    logic [CW:0]   out_count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_none,
        input  out_multi,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output out_none,
        output out_multi,
        output out_count
    );
endinterface
`default_nettype wire

// File: rtl/priority_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_seq
// Description : Sequential N-to-log2(N) priority encoder. Captures a line
//               vector on a valid/ready handshake, walks it one bit per clock,
//               then presents the winning line's code, the set-bit count and
//               none/multi-hot flags until the consumer accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_seq #(
    parameter int N             = 4,     // number of lines, power of two, >= 2
    parameter int CW            = 2,     // code width, equals clog2(N)
    parameter bit PRIORITY_HIGH = 1'b1   // 1: highest set index wins, 0: lowest
) (
    input  wire logic             clk,
    input  wire logic             rst,
    priority_encoder_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_LAST_IDX = CW'(N - 1);
    localparam logic [CW:0]   c_ONE      = (CW + 1)'(1);

    state_t        r_state;
    logic [N-1:0]  r_data;      // private copy; in_data is ignored after capture
    logic [CW-1:0] r_idx;
    logic [CW:0]   r_count;
    logic [CW-1:0] r_code;
    logic          r_found;

    logic          r_out_valid;
    logic [CW-1:0] r_out_code;
    logic          r_out_none;
    logic          r_out_multi;
    logic [CW:0]   r_out_count;

    logic          w_bit;
    logic          w_take;
    logic [CW:0]   w_count_nx;
    logic [CW-1:0] w_code_nx;

    // Scan-step arithmetic: the running totals including the bit under test,
    // so the final step can publish them in the same edge it folds them in.
    always_comb begin
        w_bit      = r_data[r_idx];
        // Low priority keeps the first hit; high priority lets later hits overwrite.
        w_take     = w_bit && (PRIORITY_HIGH || !r_found);
        w_count_nx = r_count + {{CW{1'b0}}, w_bit};
        w_code_nx  = w_take ? r_idx : r_code;
    end

    // Control FSM plus all registered results; async reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_code      <= '0;
            r_found     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_none  <= 1'b0;
            r_out_multi <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_data  <= bus.in_data;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_code  <= '0;
                        r_found <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_count <= w_count_nx;
                    r_code  <= w_code_nx;
                    r_found <= r_found | w_bit;
                    if (r_idx == c_LAST_IDX) begin
                        // Published results change only here, on entry to DONE.
                        r_out_code  <= w_code_nx;
                        r_out_count <= w_count_nx;
                        r_out_none  <= (w_count_nx == '0);
                        r_out_multi <= (w_count_nx > c_ONE);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // in_ready follows the state directly so it reads 1 throughout reset.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_none  = r_out_none;
    assign bus.out_multi = r_out_multi;
    assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_seq
// Description : Directed bench for priority_encoder_seq. Two encoders share
//               one stimulus stream, one built for highest-index priority and
//               one for lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_seq;

    localparam int N  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    priority_encoder_seq_if #(.N(N), .CW(CW)) bus_hi ();
    priority_encoder_seq_if #(.N(N), .CW(CW)) bus_lo ();

    assign bus_lo.in_valid  = bus_hi.in_valid;
    assign bus_lo.in_data   = bus_hi.in_data;
    assign bus_lo.out_ready = bus_hi.out_ready;

    priority_encoder_seq #(.N(N), .CW(CW), .PRIORITY_HIGH(1'b1)) dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (bus_hi)
    );

    priority_encoder_seq #(.N(N), .CW(CW), .PRIORITY_HIGH(1'b0)) dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (bus_lo)
    );

    always #5 clk = ~clk;

    // Present a vector for one rising edge; returns at the falling edge after acceptance.
    task automatic send(input logic [N-1:0] d);
        @(negedge clk);
        bus_hi.in_valid = 1'b1;
        bus_hi.in_data  = d;
        @(negedge clk);
        bus_hi.in_valid = 1'b0;
    endtask

    // Count rising edges until out_valid, capped so the bench cannot hang.
    task automatic wait_out(output int edges);
        edges = 0;
        while (bus_hi.out_valid !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Hand the result back so the encoder returns to IDLE.
    task automatic release_out();
        @(negedge clk);
        bus_hi.out_ready = 1'b1;
        @(negedge clk);
        bus_hi.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1;
        bus_hi.in_valid  = 1'b1;
        bus_hi.in_data   = 4'b1111;
        bus_hi.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_hi.out_valid !== 1'b0 || bus_hi.out_code !== 2'd0 || bus_hi.out_count !== 3'd0 ||
            bus_hi.out_none !== 1'b0 || bus_hi.out_multi !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: valid=%b code=%0d count=%0d none=%b multi=%b, want 0 0 0 0 0",
                     bus_hi.out_valid, bus_hi.out_code, bus_hi.out_count, bus_hi.out_none, bus_hi.out_multi);
        end
        checks++;
        if (bus_hi.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", bus_hi.in_ready);
        end
        bus_hi.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus_hi.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus_hi.in_ready);
        end

        // Abort a transaction in the middle of its scan.
        send(4'b0110);
        @(negedge clk);
        checks++;
        if (bus_hi.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL scan_in_ready: got %b want 0", bus_hi.in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_hi.in_ready !== 1'b1 || bus_hi.out_valid !== 1'b0 ||
            bus_hi.out_count !== 3'd0 || bus_hi.out_code !== 2'd0) begin
            failures++;
            $display("FAIL abort_async: ready=%b valid=%b count=%0d code=%0d, want 1 0 0 0",
                     bus_hi.in_ready, bus_hi.out_valid, bus_hi.out_count, bus_hi.out_code);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_hi.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_hi.out_valid !== 1'b0 || bus_lo.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_result: out_valid rose after aborted scan, want never");
        end
        bus_hi.out_ready = 1'b0;
    endtask

    task automatic test_single();
        int edges;
        send(4'b0100);
        wait_out(edges);
        checks++;
        if (edges != N) begin
            failures++;
            $display("FAIL single_latency: got %0d edges want %0d", edges, N);
        end
        checks++;
        if (bus_hi.out_code !== 2'd2 || bus_hi.out_count !== 3'd1 ||
            bus_hi.out_none !== 1'b0 || bus_hi.out_multi !== 1'b0) begin
            failures++;
            $display("FAIL single_hi: code=%0d count=%0d none=%b multi=%b, want 2 1 0 0",
                     bus_hi.out_code, bus_hi.out_count, bus_hi.out_none, bus_hi.out_multi);
        end
        checks++;
        if (bus_lo.out_code !== 2'd2 || bus_lo.out_count !== 3'd1) begin
            failures++;
            $display("FAIL single_lo: code=%0d count=%0d, want 2 1", bus_lo.out_code, bus_lo.out_count);
        end
        release_out();
        checks++;
        if (bus_hi.out_valid !== 1'b0 || bus_hi.in_ready !== 1'b1 || bus_hi.out_code !== 2'd2) begin
            failures++;
            $display("FAIL single_idle_hold: valid=%b ready=%b code=%0d, want 0 1 2",
                     bus_hi.out_valid, bus_hi.in_ready, bus_hi.out_code);
        end
    endtask

    task automatic test_multi();
        int edges;
        send(4'b1011);
        wait_out(edges);
        checks++;
        if (edges != N || bus_hi.out_code !== 2'd3 || bus_hi.out_count !== 3'd3 ||
            bus_hi.out_none !== 1'b0 || bus_hi.out_multi !== 1'b1) begin
            failures++;
            $display("FAIL multi_hi: edges=%0d code=%0d count=%0d none=%b multi=%b, want 4 3 3 0 1",
                     edges, bus_hi.out_code, bus_hi.out_count, bus_hi.out_none, bus_hi.out_multi);
        end
        checks++;
        if (bus_lo.out_valid !== 1'b1 || bus_lo.out_code !== 2'd0 || bus_lo.out_count !== 3'd3 ||
            bus_lo.out_none !== 1'b0 || bus_lo.out_multi !== 1'b1) begin
            failures++;
            $display("FAIL multi_lo: valid=%b code=%0d count=%0d none=%b multi=%b, want 1 0 3 0 1",
                     bus_lo.out_valid, bus_lo.out_code, bus_lo.out_count, bus_lo.out_none, bus_lo.out_multi);
        end
        release_out();
    endtask

    task automatic test_none();
        int edges;
        send(4'b0000);
        wait_out(edges);
        checks++;
        if (edges != N || bus_hi.out_code !== 2'd0 || bus_hi.out_count !== 3'd0 ||
            bus_hi.out_none !== 1'b1 || bus_hi.out_multi !== 1'b0) begin
            failures++;
            $display("FAIL none_hi: edges=%0d code=%0d count=%0d none=%b multi=%b, want 4 0 0 1 0",
                     edges, bus_hi.out_code, bus_hi.out_count, bus_hi.out_none, bus_hi.out_multi);
        end
        checks++;
        if (bus_lo.out_code !== 2'd0 || bus_lo.out_none !== 1'b1) begin
            failures++;
            $display("FAIL none_lo: code=%0d none=%b, want 0 1", bus_lo.out_code, bus_lo.out_none);
        end
        release_out();
    endtask

    task automatic test_hold();
        int edges;
        send(4'b0010);
        wait_out(edges);
        checks++;
        if (edges != N || bus_hi.out_code !== 2'd1) begin
            failures++;
            $display("FAIL hold_first: edges=%0d code=%0d, want 4 1", edges, bus_hi.out_code);
        end
        bus_hi.out_ready = 1'b0;
        bus_hi.in_valid  = 1'b1;
        bus_hi.in_data   = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus_hi.out_valid !== 1'b1 || bus_hi.out_code !== 2'd1 || bus_hi.in_ready !== 1'b0 ||
                bus_hi.out_count !== 3'd1) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b code=%0d ready=%b count=%0d, want 1 1 0 1",
                         i, bus_hi.out_valid, bus_hi.out_code, bus_hi.in_ready, bus_hi.out_count);
            end
        end
        bus_hi.out_ready = 1'b1;
        @(negedge clk);
        bus_hi.out_ready = 1'b0;
        checks++;
        if (bus_hi.out_valid !== 1'b0 || bus_hi.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: valid=%b ready=%b, want 0 1", bus_hi.out_valid, bus_hi.in_ready);
        end
        @(negedge clk);
        bus_hi.in_valid = 1'b0;
        checks++;
        if (bus_hi.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_second_accept: ready=%b, want 0", bus_hi.in_ready);
        end
        wait_out(edges);
        checks++;
        if (edges != N || bus_hi.out_code !== 2'd3 || bus_lo.out_code !== 2'd3 ||
            bus_hi.out_count !== 3'd1 || bus_hi.out_multi !== 1'b0) begin
            failures++;
            $display("FAIL hold_second: edges=%0d hi_code=%0d lo_code=%0d count=%0d multi=%b, want 4 3 3 1 0",
                     edges, bus_hi.out_code, bus_lo.out_code, bus_hi.out_count, bus_hi.out_multi);
        end
        release_out();
    endtask

    task automatic test_toggle();
        int edges;
        send(4'b1111);
        edges = 0;
        while (bus_hi.out_valid !== 1'b1 && edges < 20) begin
            bus_hi.in_data = (edges % 2 == 0) ? 4'b0000 : 4'b0101;
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != N || bus_hi.out_count !== 3'b100 || bus_hi.out_code !== 2'd3 ||
            bus_hi.out_multi !== 1'b1 || bus_hi.out_none !== 1'b0) begin
            failures++;
            $display("FAIL toggle_hi: edges=%0d count=%0d code=%0d multi=%b none=%b, want 4 4 3 1 0",
                     edges, bus_hi.out_count, bus_hi.out_code, bus_hi.out_multi, bus_hi.out_none);
        end
        checks++;
        if (bus_lo.out_count !== 3'b100 || bus_lo.out_code !== 2'd0 || bus_lo.out_multi !== 1'b1) begin
            failures++;
            $display("FAIL toggle_lo: count=%0d code=%0d multi=%b, want 4 0 1",
                     bus_lo.out_count, bus_lo.out_code, bus_lo.out_multi);
        end
        release_out();
    endtask

    initial begin
        bus_hi.in_valid  = 1'b0;
        bus_hi.in_data   = '0;
        bus_hi.out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_none();
        test_hold();
        test_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
